// File: rtl/lap_stopwatch.sv
// Stopwatch with a prescaled time counter, lap memory and browse index.
// Same-cycle pulses resolve as start_stop > clear > lap > show.
module lap_stopwatch #(
    parameter int CNT_WIDTH  = 10,
    parameter int IDX_WIDTH  = 2,
    parameter int TICK_DIV   = 500000,
    parameter int SPLIT_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_stop,
    input  logic                 lap,
    input  logic                 show,
    input  logic                 clear,
    output logic                 running,
    output logic [CNT_WIDTH-1:0] cur_time,
    output logic [CNT_WIDTH-1:0] lap_time,
    output logic [IDX_WIDTH-1:0] lap_idx,
    output logic [IDX_WIDTH:0]   lap_count,
    output logic                 full,
    output logic                 overflow
);

    localparam int unsigned LAP_DEPTH = 2 ** IDX_WIDTH;
    localparam int          PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]      PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [IDX_WIDTH:0] DEPTH_CNT = (IDX_WIDTH + 1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t               state;
    logic [PW-1:0]        presc;
    logic [CNT_WIDTH-1:0] mem [LAP_DEPTH];
    logic [CNT_WIDTH-1:0] last_ref;

    logic                 tick;
    logic                 lap_wr;
    logic [CNT_WIDTH-1:0] lap_value;
    logic [IDX_WIDTH:0]   idx_inc;
    logic [IDX_WIDTH-1:0] show_idx;

    always_comb begin
        tick      = (state == RUN) && (presc == PRESC_MAX);
        lap_wr    = (state == RUN) && !start_stop && !clear && lap &&
                    (lap_count != DEPTH_CNT);
        // Stored value uses the pre-increment count even when a tick coincides.
        lap_value = (SPLIT_MODE != 0) ? (cur_time - last_ref) : cur_time;
        idx_inc   = {1'b0, lap_idx} + 1'b1;
        show_idx  = (idx_inc >= lap_count) ? '0 : idx_inc[IDX_WIDTH-1:0];
    end

    assign full = (lap_count == DEPTH_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            presc     <= '0;
            cur_time  <= '0;
            lap_time  <= '0;
            lap_idx   <= '0;
            lap_count <= '0;
            overflow  <= 1'b0;
            last_ref  <= '0;
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            lap_time <= mem[lap_idx];
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                        presc   <= '0;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        // Stopping freezes time: a coincident tick is dropped.
                        state   <= STOP;
                        running <= 1'b0;
                        lap_idx <= '0;
                    end else begin
                        if (tick) begin
                            presc    <= '0;
                            cur_time <= cur_time + 1'b1;
                            if (&cur_time) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (lap_wr) begin
                            mem[lap_count[IDX_WIDTH-1:0]] <= lap_value;
                            last_ref  <= cur_time;
                            lap_count <= lap_count + 1'b1;
                            lap_idx   <= lap_count[IDX_WIDTH-1:0];
                        end
                    end
                end
                STOP: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                        presc   <= '0;
                    end else if (clear) begin
                        state     <= IDLE;
                        running   <= 1'b0;
                        presc     <= '0;
                        cur_time  <= '0;
                        lap_idx   <= '0;
                        lap_count <= '0;
                        overflow  <= 1'b0;
                        last_ref  <= '0;
                        for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                            mem[i] <= '0;
                        end
                    end else if (!lap && show && (lap_count != '0)) begin
                        lap_idx <= show_idx;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench: stimulus queues expected values, a negedge monitor compares.
// Two instances share stimulus: absolute-lap (dut0) and split-lap (dut1).
module tb_lap_stopwatch;

    localparam int CW = 4;
    localparam int IW = 2;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_stop = 1'b0;
    logic lap = 1'b0;
    logic show = 1'b0;
    logic clear = 1'b0;

    logic          run0, run1, full0, full1, ovf0, ovf1;
    logic [CW-1:0] cur0, cur1, lt0, lt1;
    logic [IW-1:0] idx0, idx1;
    logic [IW:0]   cnt0, cnt1;

    always #5 clk = ~clk;

    lap_stopwatch #(.CNT_WIDTH(CW), .IDX_WIDTH(IW), .TICK_DIV(TD), .SPLIT_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .show(show),
        .clear(clear), .running(run0), .cur_time(cur0), .lap_time(lt0),
        .lap_idx(idx0), .lap_count(cnt0), .full(full0), .overflow(ovf0));

    lap_stopwatch #(.CNT_WIDTH(CW), .IDX_WIDTH(IW), .TICK_DIV(TD), .SPLIT_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .show(show),
        .clear(clear), .running(run1), .cur_time(cur1), .lap_time(lt1),
        .lap_idx(idx1), .lap_count(cnt1), .full(full1), .overflow(ovf1));

    typedef enum int unsigned {F_RUN, F_CUR, F_LT, F_IDX, F_CNT, F_FULL, F_OVF} field_t;

    typedef struct {
        int unsigned dut;
        field_t      sel;
        int unsigned exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    function automatic int unsigned observe(input int unsigned d, input field_t s);
        case (s)
            F_RUN:   return (d == 0) ? int'(run0)  : int'(run1);
            F_CUR:   return (d == 0) ? int'(cur0)  : int'(cur1);
            F_LT:    return (d == 0) ? int'(lt0)   : int'(lt1);
            F_IDX:   return (d == 0) ? int'(idx0)  : int'(idx1);
            F_CNT:   return (d == 0) ? int'(cnt0)  : int'(cnt1);
            F_FULL:  return (d == 0) ? int'(full0) : int'(full1);
            default: return (d == 0) ? int'(ovf0)  : int'(ovf1);
        endcase
    endfunction

    task automatic expect1(input int unsigned d, input field_t s, input int unsigned e,
                           input string n);
        exp_t it;
        it.dut = d; it.sel = s; it.exp = e; it.name = n;
        sb.push_back(it);
    endtask

    task automatic expect2(input field_t s, input int unsigned e, input string n);
        expect1(0, s, e, n);
        expect1(1, s, e, n);
    endtask

    task automatic expect_zero(input string n);
        expect2(F_RUN, 0, {n, "_running"});
        expect2(F_CUR, 0, {n, "_cur_time"});
        expect2(F_LT, 0, {n, "_lap_time"});
        expect2(F_IDX, 0, {n, "_lap_idx"});
        expect2(F_CNT, 0, {n, "_lap_count"});
        expect2(F_FULL, 0, {n, "_full"});
        expect2(F_OVF, 0, {n, "_overflow"});
    endtask

    exp_t        mon_it;
    int unsigned mon_act;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_it  = sb.pop_front();
            mon_act = observe(mon_it.dut, mon_it.sel);
            vectors++;
            if (mon_act != mon_it.exp) begin
                miscompares++;
                $display("FAIL %s dut%0d: got %0d, expected %0d",
                         mon_it.name, mon_it.dut, mon_act, mon_it.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ncyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_ss();    start_stop = 1'b1; cyc(); start_stop = 1'b0; endtask
    task automatic pulse_lap();   lap = 1'b1;        cyc(); lap = 1'b0;        endtask
    task automatic pulse_show();  show = 1'b1;       cyc(); show = 1'b0;       endtask
    task automatic pulse_clear(); clear = 1'b1;      cyc(); clear = 1'b0;      endtask

    // From prescaler=1 (just after a lap) advance d ticks, landing on prescaler=0.
    task automatic go(input int unsigned d);
        ncyc(4 * d - 1);
    endtask

    int unsigned show_exp0 [5] = '{5, 7, 9, 2, 5};
    int unsigned show_exp1 [5] = '{3, 2, 2, 2, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        cyc();
        reset = 1'b0;
        expect_zero("reset");

        // Counting and holding
        pulse_ss();
        ncyc(12);
        expect2(F_CUR, 3, "run12_cur");
        expect2(F_RUN, 1, "run12_running");
        pulse_ss();
        ncyc(8);
        expect2(F_CUR, 3, "stop_hold_cur");
        expect2(F_RUN, 0, "stop_running");
        pulse_clear();
        cyc();
        expect_zero("clear1");

        // Lap memory fill and browse
        pulse_ss();
        ncyc(8);
        pulse_lap();
        go(3); pulse_lap();
        go(2); pulse_lap();
        go(2); pulse_lap();
        go(2); pulse_lap();
        expect2(F_CUR, 11, "fill_cur");
        expect2(F_CNT, 4, "fill_count");
        expect2(F_FULL, 1, "fill_full");
        expect2(F_IDX, 3, "fill_idx");
        expect1(0, F_LT, 9, "fill_last_abs");
        expect1(1, F_LT, 2, "fill_last_split");
        pulse_ss();
        expect2(F_IDX, 0, "stop_idx");
        cyc();
        expect1(0, F_LT, 2, "browse0_abs");
        expect1(1, F_LT, 2, "browse0_split");
        for (int i = 0; i < 5; i++) begin
            pulse_show();
            cyc();
            expect1(0, F_LT, show_exp0[i], "show_abs");
            expect1(1, F_LT, show_exp1[i], "show_split");
        end
        pulse_lap();
        expect2(F_CNT, 4, "lap_in_stop_count");
        expect2(F_IDX, 1, "lap_in_stop_idx");
        pulse_clear();
        cyc();
        expect_zero("clear2");

        // Split deltas, show wrap, clear ignored in RUN, reset mid-run
        pulse_ss();
        ncyc(12);
        pulse_lap();
        go(5);
        pulse_lap();
        expect2(F_CNT, 2, "split_count");
        pulse_ss();
        cyc();
        expect2(F_LT, 3, "split_lap0");
        pulse_show(); cyc();
        expect1(0, F_LT, 8, "split_lap1_abs");
        expect1(1, F_LT, 5, "split_lap1_split");
        pulse_show(); cyc();
        expect2(F_IDX, 0, "show_wrap_idx");
        expect2(F_LT, 3, "show_wrap_lt");
        pulse_ss();
        pulse_clear();
        expect2(F_RUN, 1, "clear_in_run_running");
        expect2(F_CNT, 2, "clear_in_run_count");
        ncyc(5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_zero("reset_mid_run");

        // Wrap and sticky overflow
        pulse_ss();
        ncyc(64 * TD);
        expect2(F_CUR, 0, "wrap_cur");
        expect2(F_OVF, 1, "wrap_overflow");
        pulse_ss();
        expect2(F_OVF, 1, "overflow_sticky");
        pulse_clear();
        cyc();
        expect_zero("clear3");

        // start_stop + lap + tick together, then lap coinciding with a tick
        pulse_ss();
        ncyc(3);
        start_stop = 1'b1; lap = 1'b1;
        cyc();
        start_stop = 1'b0; lap = 1'b0;
        expect2(F_RUN, 0, "ss_lap_tick_running");
        expect2(F_CNT, 0, "ss_lap_tick_count");
        expect2(F_CUR, 0, "ss_lap_tick_cur");
        pulse_ss();
        ncyc(24 + 3);
        pulse_lap();
        expect2(F_CUR, 7, "lap_tick_cur");
        expect2(F_CNT, 1, "lap_tick_count");
        cyc();
        expect2(F_LT, 6, "lap_tick_stored");

        ncyc(2);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter CNT_WIDTH, default 10: width of the time counter and of each stored lap value.
REQ-002 Parameter IDX_WIDTH, default 2: lap memory depth is LAP_DEPTH = 2**IDX_WIDTH entries.
REQ-003 Parameter TICK_DIV, default 500000: clk cycles per time increment, legal range >= 2.
REQ-004 Parameter SPLIT_MODE, default 0: 0 stores the absolute count per lap; 1 stores the delta since the previous lap.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start_stop  input  1  single-cycle pulse that toggles run/stop.
REQ-008 lap  input  1  single-cycle pulse that records a lap while running.
REQ-009 show  input  1  single-cycle pulse that advances the browse index while stopped.
REQ-010 clear  input  1  single-cycle pulse that zeroes the counter and lap memory while stopped.
REQ-011 running  output  1  high in state RUN.
REQ-012 cur_time  output  CNT_WIDTH  live counter value.
REQ-013 lap_time  output  CNT_WIDTH  lap memory entry at lap_idx, registered.
REQ-014 lap_idx  output  IDX_WIDTH  browse/write index.
REQ-015 lap_count  output  IDX_WIDTH+1  number of valid laps, range 0..LAP_DEPTH.
REQ-016 full  output  1  high when lap_count == LAP_DEPTH.
REQ-017 overflow  output  1  sticky flag; high once cur_time has wrapped.

Function
REQ-018 FSM states are IDLE, RUN and STOP; running SHALL be high only in RUN.
REQ-019 Transitions: IDLE -start_stop-> RUN; RUN -start_stop-> STOP; STOP -start_stop-> RUN; STOP -clear-> IDLE.
REQ-020 Priority among same-cycle pulses SHALL be start_stop > clear > lap > show; a lower-priority pulse in that cycle SHALL be ignored.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, emit a one-cycle tick at TICK_DIV-1, and reset to 0 on every entry to RUN.
REQ-022 On tick, cur_time SHALL increment modulo 2**CNT_WIDTH; on a wrap from all-ones to 0, overflow SHALL set and stay set until reset or clear.
REQ-023 In STOP and IDLE, cur_time and the prescaler SHALL hold.
REQ-024 A lap pulse in RUN with lap_count < LAP_DEPTH SHALL write mem[lap_count], then increment lap_count and set lap_idx to the written index.
REQ-025 The stored value SHALL be the pre-increment cur_time when tick and lap coincide.
REQ-026 In SPLIT_MODE=1, the stored value SHALL be cur_time minus the last lap's absolute value, modulo 2**CNT_WIDTH; the last-lap reference SHALL be 0 after reset or clear.
REQ-027 A lap pulse when full SHALL be ignored, with memory, lap_count and lap_idx unchanged.
REQ-028 A lap pulse outside RUN SHALL be ignored.
REQ-029 show in STOP with lap_count > 0 SHALL set lap_idx to (lap_idx+1) mod lap_count; it SHALL be ignored in other states or when lap_count == 0.
REQ-030 Entry to STOP SHALL set lap_idx to 0.
REQ-031 lap_time SHALL equal mem[lap_idx] one cycle after any change of lap_idx or write to that entry.
REQ-032 clear in STOP SHALL zero cur_time, the prescaler, lap_count, lap_idx, overflow, all memory entries and the split reference, with lap_time 0 on the next cycle.
REQ-033 start_stop in RUN SHALL not modify cur_time or the lap memory.

Reset
REQ-034 reset SHALL override all inputs and take effect on the next rising edge, including mid-count or mid-browse.
REQ-035 After reset: state IDLE, running=0, cur_time=0, lap_time=0, lap_idx=0, lap_count=0, full=0, overflow=0, prescaler=0, all memory entries 0.

Verification (TICK_DIV=4, CNT_WIDTH=4, IDX_WIDTH=2)
REQ-036 reset, then start_stop, then 12 clocks -> cur_time=3, running=1; start_stop, then 8 clocks -> cur_time stays 3, running=0.
REQ-037 In RUN, lap at cur_time 2, 5, 7, 9 and 11 -> lap_count=4, full=1, mem={2,5,7,9}; fifth lap ignored; after stop, show x5 -> lap_time 5,7,9,2,5.
REQ-038 SPLIT_MODE=1, laps at cur_time 3 and 8 -> mem[0]=3, mem[1]=5.
REQ-039 Run 64 ticks with no laps -> cur_time wraps to 0 and overflow=1; stop then clear -> IDLE, all outputs 0.
REQ-040 start_stop, lap and tick in the same cycle -> state STOP, no lap written; separately, lap with tick at cur_time=6 -> stored 6, cur_time 7.
REQ-041 reset asserted mid-RUN with lap_count=2 -> all REQ-035 values on the next cycle; clear pulse in RUN -> ignored.
